data_format_adapter_sop_ram_wr_arbiter: RTL and testbench
=========================================================

Name: data_format_adapter_sop_ram_wr_arbiter

Overview:
Shares the single write port of the lookahead SOP memory between NUM_REQ Avalon-MM-style write masters using round-robin arbitration. It also contains a clear sequencer that, on command, sweeps every memory location to zero while holding off all requesters. It sits between the data format adapter's write sources and the memory's write interface. The memory read port is untouched.

Parameters:
NUM_REQ, 2, number of write requesters (2..8)
DEPTH, 4, memory depth in words
ADDRESS_WIDTH, 2, memory address width; must satisfy 2**ADDRESS_WIDTH >= DEPTH
DATA_WIDTH, 8, write data width

Ports:
clk  in  1  clock; single clock domain
reset_n  in  1  asynchronous active-low reset
req_address  in  NUM_REQ*ADDRESS_WIDTH  per-requester address; requester i occupies slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
req_writedata  in  NUM_REQ*DATA_WIDTH  per-requester write data, packed the same way
req_write  in  NUM_REQ  per-requester write request
req_waitrequest  out  NUM_REQ  per-requester stall; a write is accepted when req_write[i]=1 and req_waitrequest[i]=0
mem_wr_address  out  ADDRESS_WIDTH  to memory wr_address
mem_wr_writedata  out  DATA_WIDTH  to memory wr_writedata
mem_wr_write  out  1  to memory wr_write
mem_wr_waitrequest  in  1  from memory wr_waitrequest
clear_start  in  1  single-cycle pulse requesting a full clear
clear_busy  out  1  high while the clear sweep is running
clear_done  out  1  single-cycle pulse after the last clear write

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=ARB, rr_ptr=0, clear_addr=0, clear_busy=0, clear_done=0.
  - All req_waitrequest=1; mem_wr_write=0.
- States: ARB, CLEAR. No other states.
- ARB state:
  - Grant is combinational. Candidates are indices i with req_write[i]=1.
  - The first candidate found scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ) wins.
  - mem_wr_* = the winner's address, data and write=1.
  - req_waitrequest[winner] = mem_wr_waitrequest. All other bits are 1.
  - With no candidate: mem_wr_write=0, all req_waitrequest=1, and mem_wr_address/data are 0.
- Pointer update:
  - On an accepted write (winner present and mem_wr_waitrequest=0), rr_ptr <= winner+1 mod NUM_REQ at the clock edge.
  - rr_ptr holds otherwise.
- Requester obligations: a requester holds address, data and write stable while stalled. The arbiter does not re-arbitrate a stalled winner away. The grant stays on the same winner as long as its req_write stays 1, because rr_ptr does not move.
- Memory stall: while mem_wr_waitrequest=1 (memory in reset/init), no transfer completes, rr_ptr holds, and clear_addr holds.
- clear_start in ARB:
  - Next state is CLEAR; clear_busy=1 from the next cycle; clear_addr=0.
  - Any write accepted in the same cycle as clear_start completes normally.
- CLEAR state:
  - All req_waitrequest=1.
  - mem_wr_write=1, mem_wr_address=clear_addr, mem_wr_writedata=0.
  - Each cycle with mem_wr_waitrequest=0: if clear_addr==DEPTH-1, go to ARB, clear_busy<=0, clear_done<=1 for one cycle, clear_addr<=0. Otherwise clear_addr<=clear_addr+1.
  - A clear takes DEPTH unstalled cycles.
- clear_start while in CLEAR: ignored; no restart and no extra done pulse.
- clear_done: registered, high exactly one cycle, coincident with the first ARB cycle after the sweep.
- Reset mid-clear: asynchronous return to ARB, clear_busy=0, and no clear_done pulse. Memory content is then unspecified.
- Throughput: one accepted write per cycle in ARB. Latency from request to memory port is 0 cycles (combinational path).
- Memory read data returns 2 cycles after the read address. The memory's lookahead bypass covers writes issued through this block, with no added write latency.

Test Plan:
- Reset: reset_n=0 then released; memory wr_waitrequest=1 for 2 cycles -> all req_waitrequest=1 and mem_wr_write=0 throughout; after wr_waitrequest falls, a single req_write[0] at address 1, data 0x5A is accepted in the same cycle.
- Fairness: req_write=2'b11 held for 6 cycles with mem_wr_waitrequest=0 -> grants alternate 0,1,0,1,0,1, and each requester sees exactly 3 accepted writes.
- Stall hold: req_write=2'b11, rr_ptr=1, mem_wr_waitrequest=1 for 3 cycles -> requester 1 stays granted and rr_ptr stays 1; on release requester 1 is accepted, then requester 0.
- Clear: memory preloaded with 0xFF at addresses 0..3; clear_start pulse -> clear_busy high 4 cycles with mem_wr_address 0,1,2,3 and data 0; clear_done pulses once; all 4 read-backs return 0x00; requesters stalled during the sweep.
- Clear with contention: clear_start issued while req_write[1]=1 -> the requester-1 write completes that cycle, then the sweep runs; a second clear_start during the sweep yields no extra clear_done.
- Reset mid-clear: reset_n asserted at clear_addr=2 -> clear_busy=0 immediately and clear_done never pulses; after release, normal ARB operation resumes with rr_ptr=0.

Source files
------------

// File: rtl/data_format_adapter_sop_ram_wr_arbiter.sv
// Round-robin arbiter for the lookahead SOP memory write port,
// with a built-in sweep that zeroes every location on command.
module data_format_adapter_sop_ram_wr_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int DEPTH         = 4,
  parameter int ADDRESS_WIDTH = 2,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_writedata,
  input  logic [NUM_REQ-1:0]            req_write,
  output logic [NUM_REQ-1:0]            req_waitrequest,
  output logic [ADDRESS_WIDTH-1:0]      mem_wr_address,
  output logic [DATA_WIDTH-1:0]         mem_wr_writedata,
  output logic                          mem_wr_write,
  input  logic                          mem_wr_waitrequest,
  input  logic                          clear_start,
  output logic                          clear_busy,
  output logic                          clear_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] ARB   = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]               state;
  logic [PW-1:0]            rr_ptr;
  logic [ADDRESS_WIDTH-1:0] clear_addr;
  logic                     hit;
  logic                     grant;
  logic [PW-1:0]            win;
  logic [PW-1:0]            idx;

  // Scan downward so the candidate closest to rr_ptr is assigned last.
  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_write[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  assign grant = hit && reset_n && (state == ARB);

  always_comb begin
    req_waitrequest  = '1;
    mem_wr_write     = 1'b0;
    mem_wr_address   = '0;
    mem_wr_writedata = '0;
    if (reset_n && state == CLEAR) begin
      mem_wr_write   = 1'b1;
      mem_wr_address = clear_addr;
    end else if (grant) begin
      mem_wr_write     = 1'b1;
      mem_wr_address   =
        req_address[win*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      mem_wr_writedata =
        req_writedata[win*DATA_WIDTH +: DATA_WIDTH];
      req_waitrequest[win] = mem_wr_waitrequest;
    end
  end

  assign clear_busy = (state == CLEAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB;
      rr_ptr     <= '0;
      clear_addr <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      if (state == ARB) begin
        if (grant && !mem_wr_waitrequest) begin
          if (win == PW'(NUM_REQ - 1))
            rr_ptr <= '0;
          else
            rr_ptr <= win + 1'b1;
        end
        if (clear_start) begin
          state      <= CLEAR;
          clear_addr <= '0;
        end
      end else if (!mem_wr_waitrequest) begin
        if (clear_addr == ADDRESS_WIDTH'(DEPTH - 1)) begin
          state      <= ARB;
          clear_done <= 1'b1;
          clear_addr <= '0;
        end else begin
          clear_addr <= clear_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_format_adapter_sop_ram_wr_arbiter.sv
// Scoreboard bench for the SOP memory write arbiter:
// stimulus pushes expected writes, a negedge monitor pops them.
module tb_data_format_adapter_sop_ram_wr_arbiter;

  localparam int NR = 2;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int DP = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [NR*AW-1:0] req_address;
  logic [NR*DW-1:0] req_writedata;
  logic [NR-1:0]  req_write;
  logic [NR-1:0]  req_waitrequest;
  logic [AW-1:0]  mem_wr_address;
  logic [DW-1:0]  mem_wr_writedata;
  logic           mem_wr_write;
  logic           mem_wr_waitrequest;
  logic           clear_start;
  logic           clear_busy;
  logic           clear_done;

  data_format_adapter_sop_ram_wr_arbiter #(
    .NUM_REQ(NR), .DEPTH(DP),
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_address(req_address),
    .req_writedata(req_writedata),
    .req_write(req_write),
    .req_waitrequest(req_waitrequest),
    .mem_wr_address(mem_wr_address),
    .mem_wr_writedata(mem_wr_writedata),
    .mem_wr_write(mem_wr_write),
    .mem_wr_waitrequest(mem_wr_waitrequest),
    .clear_start(clear_start),
    .clear_busy(clear_busy),
    .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int src;
    int addr;
    int data;
  } exp_t;

  exp_t      q[$];
  int        nvec = 0;
  int        nerr = 0;
  int        done_cnt = 0;
  int        acc_cnt[NR];
  logic [DW-1:0] mem[DP];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(int s, int a, int d);
    exp_t e;
    e.src = s;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic setr(int i, int a, int d);
    req_address[i*AW +: AW]   = AW'(a);
    req_writedata[i*DW +: DW] = DW'(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // -1 marks a clear-sweep write (no requester granted)
  always @(negedge clk) begin
    if (reset_n && mem_wr_write && !mem_wr_waitrequest) begin
      int src;
      exp_t e;
      src = -1;
      for (int i = 0; i < NR; i++)
        if (!req_waitrequest[i]) src = i;
      if (src >= 0) acc_cnt[src]++;
      if (q.size() == 0) begin
        chk("unexpected_write", 32'(mem_wr_address), 32'hFFFF);
      end else begin
        e = q.pop_front();
        chk("sb_src", 32'(src), 32'(e.src));
        chk("sb_addr", 32'(mem_wr_address), 32'(e.addr));
        chk("sb_data", 32'(mem_wr_writedata), 32'(e.data));
      end
    end
  end

  always @(negedge clk)
    if (clear_done) done_cnt++;

  always @(posedge clk)
    if (reset_n && mem_wr_write && !mem_wr_waitrequest)
      mem[mem_wr_address] <= mem_wr_writedata;

  initial begin
    int d0;
    int c0;
    int c1;
    for (int i = 0; i < NR; i++) acc_cnt[i] = 0;
    reset_n = 1'b0;
    mem_wr_waitrequest = 1'b1;
    req_write = 2'b01;
    req_address = '0;
    req_writedata = '0;
    clear_start = 1'b0;
    setr(0, 1, 8'h5A);

    // reset with a pending request
    step();
    @(negedge clk);
    chk("rst_wait", 32'(req_waitrequest), 32'h3);
    chk("rst_write", 32'(mem_wr_write), 32'h0);
    chk("rst_busy", 32'(clear_busy), 32'h0);
    chk("rst_done", 32'(clear_done), 32'h0);
    step();
    req_write = 2'b00;
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("init_wait", 32'(req_waitrequest), 32'h3);
      chk("init_write", 32'(mem_wr_write), 32'h0);
      step();
    end
    mem_wr_waitrequest = 1'b0;
    req_write = 2'b01;
    push(0, 1, 8'h5A);
    step();

    // move rr_ptr back to 0 via requester 1
    setr(1, 2, 8'h11);
    req_write = 2'b10;
    push(1, 2, 8'h11);
    step();

    // fairness
    setr(0, 0, 8'hA0);
    setr(1, 3, 8'hB1);
    req_write = 2'b11;
    c0 = acc_cnt[0];
    c1 = acc_cnt[1];
    for (int i = 0; i < 6; i++)
      if (i % 2 == 0) push(0, 0, 8'hA0);
      else push(1, 3, 8'hB1);
    repeat (6) step();
    chk("fair_cnt0", 32'(acc_cnt[0] - c0), 32'd3);
    chk("fair_cnt1", 32'(acc_cnt[1] - c1), 32'd3);

    // rr_ptr -> 1, then memory stall with both requesting
    req_write = 2'b01;
    push(0, 0, 8'hA0);
    step();
    req_write = 2'b11;
    mem_wr_waitrequest = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_wait", 32'(req_waitrequest), 32'h3);
      chk("stall_addr", 32'(mem_wr_address), 32'h3);
      chk("stall_data", 32'(mem_wr_writedata), 32'hB1);
      step();
    end
    mem_wr_waitrequest = 1'b0;
    push(1, 3, 8'hB1);
    push(0, 0, 8'hA0);
    step();
    step();
    req_write = 2'b00;

    // preload 0xFF
    for (int a = 0; a < DP; a++) begin
      setr(0, a, 8'hFF);
      req_write = 2'b01;
      push(0, a, 8'hFF);
      step();
    end
    req_write = 2'b00;
    @(negedge clk);
    chk("preload_mem3", 32'(mem[3]), 32'hFF);

    // clear sweep with requester 0 waiting
    step();
    clear_start = 1'b1;
    d0 = done_cnt;
    step();
    clear_start = 1'b0;
    for (int a = 0; a < DP; a++) push(-1, a, 0);
    setr(0, 3, 8'h77);
    req_write = 2'b01;
    repeat (DP) begin
      @(negedge clk);
      chk("clr_busy", 32'(clear_busy), 32'h1);
      chk("clr_wait", 32'(req_waitrequest), 32'h3);
      step();
    end
    push(0, 3, 8'h77);
    @(negedge clk);
    chk("clr_busy_end", 32'(clear_busy), 32'h0);
    chk("clr_done", 32'(clear_done), 32'h1);
    for (int a = 0; a < DP; a++)
      chk("clr_readback", 32'(mem[a]), 32'h0);
    step();
    req_write = 2'b00;
    @(negedge clk);
    chk("clr_done_pulse", 32'(clear_done), 32'h0);
    chk("clr_done_cnt", 32'(done_cnt - d0), 32'd1);

    // clear with contention and a repeated clear_start
    step();
    setr(1, 1, 8'h33);
    req_write = 2'b10;
    clear_start = 1'b1;
    d0 = done_cnt;
    push(1, 1, 8'h33);
    for (int a = 0; a < DP; a++) push(-1, a, 0);
    step();
    req_write = 2'b00;
    clear_start = 1'b0;
    step();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("cont_busy_end", 32'(clear_busy), 32'h0);
    chk("cont_done", 32'(clear_done), 32'h1);
    step();
    step();
    chk("cont_done_cnt", 32'(done_cnt - d0), 32'd1);

    // reset during the sweep at clear_addr 2
    clear_start = 1'b1;
    d0 = done_cnt;
    for (int a = 0; a < 3; a++) push(-1, a, 0);
    step();
    clear_start = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("mid_addr", 32'(mem_wr_address), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_busy", 32'(clear_busy), 32'h0);
    chk("mid_write", 32'(mem_wr_write), 32'h0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    repeat (3) step();
    chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
    setr(0, 2, 8'hC0);
    setr(1, 1, 8'hC1);
    req_write = 2'b11;
    push(0, 2, 8'hC0);
    push(1, 1, 8'hC1);
    step();
    step();
    req_write = 2'b00;
    step();
    step();
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
